// File: rtl/mlp2_dot_engine.sv
// Two-layer fully-connected signed inference engine (no bias), one neuron per cycle.
// Layer 1 fills the hidden registers (optional ReLU); layer 2 produces saturated or wrapped outputs.
module mlp2_dot_engine #(
  parameter int N_IN  = 4,
  parameter int N_HID = 4,
  parameter int N_OUT = 2,
  parameter int DW    = 5,
  parameter int OW    = 17,
  parameter int SAT   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_ready,
  input  logic                      relu_en,
  input  logic [N_IN*DW-1:0]        x_flat,
  input  logic [N_HID*N_IN*DW-1:0]  w1_flat,
  input  logic [N_OUT*N_HID*DW-1:0] w2_flat,
  output logic                      busy,
  output logic [N_OUT*OW-1:0]       out_flat,
  output logic [N_OUT-1:0]          out_ready
);

  localparam int HW   = 2*DW + $clog2(N_IN);
  localparam int AW   = HW + DW + $clog2(N_HID);
  localparam int EW   = (AW > OW) ? AW : OW;
  localparam int NMAX = (N_HID > N_OUT) ? N_HID : N_OUT;
  localparam int IW   = (NMAX > 1) ? $clog2(NMAX) : 1;

  localparam logic signed [EW-1:0] OMAX = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [EW-1:0] OMIN = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_L1, S_L2} state_t;

  state_t                      state_q, state_d;
  logic                        busy_q, busy_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic                        relu_q, relu_d;
  logic [N_IN*DW-1:0]          x_q, x_d;
  logic [N_HID*N_IN*DW-1:0]    w1_q, w1_d;
  logic [N_OUT*N_HID*DW-1:0]   w2_q, w2_d;
  logic signed [HW-1:0]        hid_q [N_HID];
  logic signed [HW-1:0]        hid_d [N_HID];
  logic [N_OUT*OW-1:0]         out_q, out_d;
  logic [N_OUT-1:0]            out_ready_q, out_ready_d;

  logic signed [HW-1:0]        l1_sum;
  logic signed [HW-1:0]        hid_new;
  logic signed [AW-1:0]        l2_sum;
  logic signed [EW-1:0]        l2_ext;
  logic [OW-1:0]               out_new;

  // Layer-1 dot product for hidden neuron idx_q, full precision.
  always_comb begin
    l1_sum = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      l1_sum = l1_sum + HW'($signed(x_q[i*DW +: DW])) *
                        HW'($signed(w1_q[(int'(idx_q)*N_IN + i)*DW +: DW]));
    end
    hid_new = (relu_q && l1_sum[HW-1]) ? '0 : l1_sum;
  end

  // Layer-2 dot product for output neuron idx_q, then clamp or wrap to OW bits.
  always_comb begin
    l2_sum = '0;
    for (int unsigned j = 0; j < N_HID; j++) begin
      l2_sum = l2_sum + AW'(hid_q[j]) *
                        AW'($signed(w2_q[(int'(idx_q)*N_HID + j)*DW +: DW]));
    end
    l2_ext = EW'(l2_sum);
    if (SAT != 0 && l2_ext > OMAX) begin
      out_new = OMAX[OW-1:0];
    end else if (SAT != 0 && l2_ext < OMIN) begin
      out_new = OMIN[OW-1:0];
    end else begin
      out_new = l2_ext[OW-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    idx_d       = idx_q;
    relu_d      = relu_q;
    x_d         = x_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    hid_d       = hid_q;
    out_d       = out_q;
    out_ready_d = out_ready_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_ready) begin
          x_d         = x_flat;
          w1_d        = w1_flat;
          w2_d        = w2_flat;
          relu_d      = relu_en;
          out_ready_d = '0;
          busy_d      = 1'b1;
          idx_d       = '0;
          state_d     = S_L1;
        end
      end
      S_L1: begin
        hid_d[idx_q] = hid_new;
        if (idx_q == IW'(N_HID-1)) begin
          idx_d   = '0;
          state_d = S_L2;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_L2: begin
        out_d[int'(idx_q)*OW +: OW] = out_new;
        out_ready_d[idx_q]          = 1'b1;
        if (idx_q == IW'(N_OUT-1)) begin
          idx_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      idx_q       <= '0;
      relu_q      <= 1'b0;
      x_q         <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      hid_q       <= '{default: '0};
      out_q       <= '0;
      out_ready_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      idx_q       <= idx_d;
      relu_q      <= relu_d;
      x_q         <= x_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      hid_q       <= hid_d;
      out_q       <= out_d;
      out_ready_q <= out_ready_d;
    end
  end

  assign busy      = busy_q;
  assign out_flat  = out_q;
  assign out_ready = out_ready_q;

endmodule

// File: tb/tb_mlp2_dot_engine.sv
// Directed bench for mlp2_dot_engine: default instance plus OW=16 saturating and wrapping instances.
module tb_mlp2_dot_engine;

  logic        clk = 1'b0;
  logic        rst, in_ready, relu_en;
  logic [19:0] x_flat;
  logic [79:0] w1_flat;
  logic [39:0] w2_flat;
  logic        busy_a, busy_b, busy_c;
  logic [33:0] out_a;
  logic [31:0] out_b, out_c;
  logic [1:0]  rdy_a, rdy_b, rdy_c;

  int checks = 0;
  int failures = 0;
  int xv [4];
  int w1v [4][4];
  int w2v [2][4];
  int n;

  always #5 clk = ~clk;

  mlp2_dot_engine #(.N_IN(4), .N_HID(4), .N_OUT(2), .DW(5), .OW(17), .SAT(1)) u_dut (
    .clk(clk), .rst(rst), .in_ready(in_ready), .relu_en(relu_en),
    .x_flat(x_flat), .w1_flat(w1_flat), .w2_flat(w2_flat),
    .busy(busy_a), .out_flat(out_a), .out_ready(rdy_a));

  mlp2_dot_engine #(.OW(16), .SAT(1)) u_sat16 (
    .clk(clk), .rst(rst), .in_ready(in_ready), .relu_en(relu_en),
    .x_flat(x_flat), .w1_flat(w1_flat), .w2_flat(w2_flat),
    .busy(busy_b), .out_flat(out_b), .out_ready(rdy_b));

  mlp2_dot_engine #(.OW(16), .SAT(0)) u_wrap16 (
    .clk(clk), .rst(rst), .in_ready(in_ready), .relu_en(relu_en),
    .x_flat(x_flat), .w1_flat(w1_flat), .w2_flat(w2_flat),
    .busy(busy_c), .out_flat(out_c), .out_ready(rdy_c));

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] lane_a(input int k);
    logic signed [16:0] t;
    t = out_a[k*17 +: 17];
    return 32'(t);
  endfunction

  function automatic logic signed [31:0] lane16(input logic [31:0] v, input int k);
    logic signed [15:0] t;
    t = v[k*16 +: 16];
    return 32'(t);
  endfunction

  task automatic pack_ops();
    for (int i = 0; i < 4; i++) x_flat[i*5 +: 5] = 5'(xv[i]);
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++) w1_flat[(j*4+i)*5 +: 5] = 5'(w1v[j][i]);
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 4; j++) w2_flat[(k*4+j)*5 +: 5] = 5'(w2v[k][j]);
  endtask

  task automatic fill(input int xval, input int w1val, input int w2val);
    for (int i = 0; i < 4; i++) xv[i] = xval;
    for (int j = 0; j < 4; j++) for (int i = 0; i < 4; i++) w1v[j][i] = w1val;
    for (int k = 0; k < 2; k++) for (int j = 0; j < 4; j++) w2v[k][j] = w2val;
  endtask

  task automatic load_test1();
    xv  = '{4, 2, 4, 1};
    w1v = '{'{3, 2, 13, 0}, '{0, 0, 0, 14}, '{3, 6, 0, 15}, '{9, 0, 15, 0}};
    w2v = '{'{0, 0, 3, 11}, '{12, 0, 0, 6}};
  endtask

  // Called at a negedge; the following posedge is E0. Returns at the negedge after E0.
  task automatic start_job(input logic relu);
    pack_ops();
    relu_en  = relu;
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
    relu_en  = ~relu;
    x_flat   = '1;
    w1_flat  = '1;
    w2_flat  = '1;
  endtask

  task automatic wait_done(input string tag, input int n0);
    int cnt;
    cnt = n0;
    while (cnt < 30) begin
      @(negedge clk);
      cnt++;
      if (!busy_a) break;
    end
    check_val({tag, "_lat"}, cnt, 6);
  endtask

  task automatic check_main(input string tag, input int e0, input int e1);
    check_val({tag, "_rdy"}, 32'(rdy_a), 3);
    check_val({tag, "_out0"}, lane_a(0), e0);
    check_val({tag, "_out1"}, lane_a(1), e1);
  endtask

  initial begin
    rst = 1'b1; in_ready = 1'b0; relu_en = 1'b0;
    x_flat = '0; w1_flat = '0; w2_flat = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(busy_a), 0);
    check_val("rst_rdy", 32'(rdy_a), 0);
    check_val("rst_out", 32'(|out_a), 0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: cycle-exact latency
    load_test1();
    start_job(1'b0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 4) check_val("t1_rdy_e4", 32'(rdy_a), 0);
      if (c == 5) begin
        check_val("t1_rdy_e5", 32'(rdy_a), 1);
        check_val("t1_out0_e5", lane_a(0), 1173);
        check_val("t1_busy_e5", 32'(busy_a), 1);
      end
      if (c == 6) begin
        check_val("t1_busy_e6", 32'(busy_a), 0);
        check_main("t1", 1173, 1392);
      end
    end

    // Test 2/4: extremes, back-to-back, narrow saturating and wrapping lanes
    fill(-16, -16, -16);
    start_job(1'b0);
    wait_done("t2n", 0);
    check_main("t2n", -65536, -65536);
    check_val("t4n_sat", lane16(out_b, 0), -32768);
    check_val("t4n_wrap", lane16(out_c, 1), 0);
    fill(15, 15, 15);
    start_job(1'b0);
    check_val("t2_b2b_clr", 32'(rdy_a), 0);
    wait_done("t2p", 0);
    check_main("t2p", 54000, 54000);
    check_val("t4p_sat0", lane16(out_b, 0), 32767);
    check_val("t4p_sat1", lane16(out_b, 1), 32767);
    check_val("t4p_wrap", lane16(out_c, 0), -11536);

    // Test 3: ReLU
    fill(1, -1, 1);
    start_job(1'b0);
    wait_done("t3a", 0);
    check_main("t3a", -16, -16);
    start_job(1'b1);
    wait_done("t3b", 0);
    check_main("t3b", 0, 0);

    // Test 5: in_ready pulse while busy is ignored
    load_test1();
    start_job(1'b0);
    @(negedge clk);
    fill(15, 15, 15);
    pack_ops();
    in_ready = 1'b1;
    @(negedge clk);
    in_ready = 1'b0;
    wait_done("t5", 2);
    check_main("t5", 1173, 1392);
    @(negedge clk);
    check_val("t5_idle", 32'(busy_a), 0);

    // Test 6: reset mid-job
    fill(15, 15, 15);
    start_job(1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("t6_busy", 32'(busy_a), 0);
    check_val("t6_rdy", 32'(rdy_a), 0);
    check_val("t6_out", 32'(|out_a), 0);
    rst = 1'b0;
    load_test1();
    start_job(1'b0);
    wait_done("t6f", 0);
    check_main("t6f", 1173, 1392);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
